// File: rtl/prim_ram_2p_cfg_shift.sv
// Serial loader for the two-port RAM configuration daisy chain.
// Optional readback check of the chain return is enabled by PRIM_RAM_2P_CFG_READBACK_EN.
module prim_ram_2p_cfg_shift #(
  parameter int NumRams = 4,
  parameter int CfgW    = 20
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [CfgW-1:0] cfg_i,
  output logic            gnt_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            scan_en_o,
  output logic            scan_data_o,
  output logic            scan_update_o,
  input  logic            scan_data_i,
  output logic            err_o
);

  localparam int ChainLen = NumRams * CfgW;
`ifdef PRIM_RAM_2P_CFG_READBACK_EN
  localparam int ShiftLen = ChainLen + CfgW;
`else
  localparam int ShiftLen = ChainLen;
`endif
  localparam int CntW = $clog2(ShiftLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ShiftLen - 1);
  localparam logic [4:0]      LastIdx = 5'(CfgW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_r, state_s;
  logic [CntW-1:0]   cnt_r, cnt_s;
  logic [4:0]        idx_r, idx_s;
  logic [CfgW-1:0]   shadow_r, shadow_s;
  logic              accept_s;
  logic              en_r, data_r, update_r, done_r, busy_r, err_r, err_s;

  assign gnt_o = req_i && (state_r == IDLE);

  // Next-state, counter and bit-index logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    shadow_s = shadow_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          accept_s = 1'b1;
          shadow_s = cfg_i;
          cnt_s    = '0;
          idx_s    = 5'd0;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LastCnt) begin
          state_s = UPDATE;
        end else begin
          cnt_s = cnt_r + CntW'(1);
          idx_s = (idx_r == LastIdx) ? 5'd0 : idx_r + 5'd1;
        end
      end
      UPDATE:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

`ifdef PRIM_RAM_2P_CFG_READBACK_EN
  logic compare_s;
  // Once the chain is full, the returning bit must equal the bit now being driven.
  always_comb begin
    compare_s = (state_r == SHIFT) && (cnt_r >= CntW'(ChainLen));
    if (accept_s) begin
      err_s = 1'b0;
    end else if (compare_s && (scan_data_i != data_r)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end
  end
`else
  logic unused_scan_data;
  assign unused_scan_data = scan_data_i;
  assign err_s = 1'b0;
`endif

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= 5'd0;
      shadow_r <= '0;
      en_r     <= 1'b0;
      data_r   <= 1'b0;
      update_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shadow_r <= shadow_s;
      en_r     <= (state_s == SHIFT);
      data_r   <= (state_s == SHIFT) ? shadow_s[LastIdx - idx_s] : 1'b0;
      update_r <= (state_s == UPDATE);
      done_r   <= (state_s == DONE);
      busy_r   <= (state_s != IDLE);
      err_r    <= err_s;
    end
  end

  assign scan_en_o     = en_r;
  assign scan_data_o   = data_r;
  assign scan_update_o = update_r;
  assign done_o        = done_r;
  assign busy_o        = busy_r;
  assign err_o         = err_r;

endmodule
